rs232_link: RTL and testbench

- 8N1 UART slave on a 50 MHz clock.
- Receive path: rx is glitch-filtered, bytes are deserialised, and framed 8-byte packets are parsed.
- Write packets load a 16-bit data register. Read packets return that register over tx as an 8-byte reply.
- Sits between an external RS-232 transceiver and on-chip debug/control logic.

---
 rtl/rs232_link.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_rs232_link.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rs232_link                                                 |
// | Desc    : 8N1 UART slave: filtered rx, 8-byte packet parser, 16-bit  |
// |           data register, read replies on tx. Macro RS232_ECHO_EN     |
// |           adds low-priority echo of every valid received byte.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rs232_link #(
   parameter int         CLK_HZ           = 50000000,
   parameter logic [7:0] DEV_ADDR_HI      = 8'h30,
   parameter logic [7:0] DEV_ADDR_LO      = 8'h32,
   parameter int         PKT_TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] r_LPF_threshold,
   input  logic [1:0]  buad_setting,
   input  logic        rx,
   output logic        tx,
   output logic [7:0]  data_debug
);
   localparam logic [15:0] C_DIV_9600  = 16'(CLK_HZ / 9600);
   localparam logic [15:0] C_DIV_19200 = 16'(CLK_HZ / 19200);
   localparam logic [15:0] C_DIV_38400 = 16'(CLK_HZ / 38400);
   localparam logic [7:0]  C_STX       = 8'h02;
   localparam logic [7:0]  C_ETX       = 8'h03;
   localparam logic [7:0]  C_TO_LAST   = 8'(PKT_TIMEOUT_BITS - 1);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   rx_state_t   r_rx_state, w_rx_next;
   logic [15:0] r_div;
   logic        r_sync1, r_sync2, r_frx, r_frx_prev;
   logic [13:0] r_lpf_cnt;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_shift;
   logic        w_rx_half, w_rx_full, w_byte_valid;
   logic [2:0]  r_pidx;
   logic [7:0]  r_c0, r_dh, r_dl;
   logic        r_cmd_wr, r_cmd_rd;
   logic [15:0] r_data_reg;
   logic [15:0] r_to_clk;
   logic [7:0]  r_to_bits;
   logic        w_rd_done;
   logic        r_tx_busy, r_tx_reply;
   logic [9:0]  r_tx_sh;
   logic [3:0]  r_tx_nbit;
   logic [15:0] r_tx_cnt;
   logic [2:0]  r_tx_idx, w_tx_next_idx;
   logic [15:0] r_tx_data;
   logic [7:0]  w_reply_next;
   logic        w_tx_bit_end;
`ifdef RS232_ECHO_EN
   logic        r_echo_pend;
   logic [7:0]  r_echo_byte;
`endif

   // Divisor only changes between frames so a bit period never shifts mid-byte
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div <= C_DIV_9600;
      end else if (r_rx_state == RX_IDLE && !r_tx_busy) begin
         case (buad_setting)
            2'd1:    r_div <= C_DIV_19200;
            2'd2:    r_div <= C_DIV_38400;
            default: r_div <= C_DIV_9600;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_frx      <= 1'b1;
         r_frx_prev <= 1'b1;
         r_lpf_cnt  <= '0;
      end else begin
         r_sync1    <= rx;
         r_sync2    <= r_sync1;
         r_frx_prev <= r_frx;
         if (r_sync2 == r_frx) begin
            r_lpf_cnt <= '0;
         end else if (r_lpf_cnt + 14'd1 >= r_LPF_threshold) begin
            r_frx     <= r_sync2;
            r_lpf_cnt <= '0;
         end else begin
            r_lpf_cnt <= r_lpf_cnt + 14'd1;
         end
      end
   end

   assign w_rx_half = (r_rx_cnt == (r_div >> 1) - 16'd1);
   assign w_rx_full = (r_rx_cnt == r_div - 16'd1);

   always_ff @(posedge clk) begin
      if (!rst) r_rx_state <= RX_IDLE;
      else      r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next    = r_rx_state;
      w_byte_valid = 1'b0;
      case (r_rx_state)
         RX_IDLE:  if (r_frx_prev && !r_frx) w_rx_next = RX_START;
         RX_START: if (w_rx_half) w_rx_next = r_frx ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_full && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
         RX_STOP: begin
            if (w_rx_full) begin
               w_rx_next    = RX_IDLE;
               w_byte_valid = r_frx;
            end
         end
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         data_debug <= '0;
      end else begin
         if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_rx_full)
            r_rx_cnt <= '0;
         else
            r_rx_cnt <= r_rx_cnt + 16'd1;
         if (r_rx_state == RX_IDLE)
            r_rx_bit <= '0;
         if (r_rx_state == RX_DATA && w_rx_full) begin
            r_rx_shift <= {r_frx, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
         if (w_byte_valid)
            data_debug <= r_rx_shift;
      end
   end

   assign w_rd_done = w_byte_valid && (r_pidx == 3'd7) && (r_rx_shift == C_ETX) && r_cmd_rd;

   // Index 0 waits for STX; 1..7 expect AH, AL, C0, C1, DH, DL, ETX
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pidx     <= '0;
         r_c0       <= '0;
         r_dh       <= '0;
         r_dl       <= '0;
         r_cmd_wr   <= 1'b0;
         r_cmd_rd   <= 1'b0;
         r_data_reg <= '0;
         r_to_clk   <= '0;
         r_to_bits  <= '0;
      end else if (w_byte_valid) begin
         r_to_clk  <= '0;
         r_to_bits <= '0;
         if (r_rx_shift == C_STX) begin
            r_pidx <= 3'd1;
         end else begin
            case (r_pidx)
               3'd0: r_pidx <= 3'd0;
               3'd1: r_pidx <= (r_rx_shift == DEV_ADDR_HI) ? 3'd2 : 3'd0;
               3'd2: r_pidx <= (r_rx_shift == DEV_ADDR_LO) ? 3'd3 : 3'd0;
               3'd3: begin
                  r_c0   <= r_rx_shift;
                  r_pidx <= 3'd4;
               end
               3'd4: begin
                  r_cmd_wr <= (r_c0 == 8'h30) && (r_rx_shift == 8'h33);
                  r_cmd_rd <= (r_c0 == 8'h00) && (r_rx_shift == 8'h00);
                  r_pidx   <= (((r_c0 == 8'h30) && (r_rx_shift == 8'h33)) ||
                               ((r_c0 == 8'h00) && (r_rx_shift == 8'h00))) ? 3'd5 : 3'd0;
               end
               3'd5: begin
                  r_dh   <= r_rx_shift;
                  r_pidx <= 3'd6;
               end
               3'd6: begin
                  r_dl   <= r_rx_shift;
                  r_pidx <= 3'd7;
               end
               default: begin
                  if (r_rx_shift == C_ETX && r_cmd_wr)
                     r_data_reg <= {r_dh, r_dl};
                  r_pidx <= 3'd0;
               end
            endcase
         end
      end else if (r_pidx != 3'd0) begin
         if (r_to_clk == r_div - 16'd1) begin
            r_to_clk <= '0;
            if (r_to_bits == C_TO_LAST) begin
               r_to_bits <= '0;
               r_pidx    <= 3'd0;
            end else begin
               r_to_bits <= r_to_bits + 8'd1;
            end
         end else begin
            r_to_clk <= r_to_clk + 16'd1;
         end
      end else begin
         r_to_clk  <= '0;
         r_to_bits <= '0;
      end
   end

   assign w_tx_next_idx = r_tx_idx + 3'd1;
   assign w_tx_bit_end  = (r_tx_cnt == r_div - 16'd1);

   always_comb begin
      w_reply_next = C_ETX;
      case (w_tx_next_idx)
         3'd0:    w_reply_next = C_STX;
         3'd1:    w_reply_next = DEV_ADDR_HI;
         3'd2:    w_reply_next = DEV_ADDR_LO;
         3'd3:    w_reply_next = 8'h00;
         3'd4:    w_reply_next = 8'h00;
         3'd5:    w_reply_next = r_tx_data[15:8];
         3'd6:    w_reply_next = r_tx_data[7:0];
         default: w_reply_next = C_ETX;
      endcase
   end

   // Shift register holds {stop, data, start}; idle shifts keep it all ones
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tx_busy  <= 1'b0;
         r_tx_reply <= 1'b0;
         r_tx_sh    <= '1;
         r_tx_nbit  <= '0;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_data  <= '0;
`ifdef RS232_ECHO_EN
         r_echo_pend <= 1'b0;
         r_echo_byte <= '0;
`endif
      end else begin
         if (w_rd_done && !r_tx_busy) begin
            r_tx_busy  <= 1'b1;
            r_tx_reply <= 1'b1;
            r_tx_idx   <= '0;
            r_tx_data  <= r_data_reg;
            r_tx_sh    <= {1'b1, C_STX, 1'b0};
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
`ifdef RS232_ECHO_EN
            r_echo_pend <= 1'b0;
`endif
         end
`ifdef RS232_ECHO_EN
         else if (!r_tx_busy && (w_byte_valid || r_echo_pend)) begin
            r_tx_busy   <= 1'b1;
            r_tx_reply  <= 1'b0;
            r_tx_sh     <= {1'b1, (w_byte_valid ? r_rx_shift : r_echo_byte), 1'b0};
            r_tx_cnt    <= '0;
            r_tx_nbit   <= '0;
            r_echo_pend <= 1'b0;
         end
`endif
         else if (r_tx_busy) begin
            if (w_tx_bit_end) begin
               r_tx_cnt <= '0;
               if (r_tx_nbit == 4'd9) begin
                  r_tx_nbit <= '0;
                  if (r_tx_reply && r_tx_idx != 3'd7) begin
                     r_tx_idx <= w_tx_next_idx;
                     r_tx_sh  <= {1'b1, w_reply_next, 1'b0};
                  end else begin
                     r_tx_busy  <= 1'b0;
                     r_tx_reply <= 1'b0;
                  end
               end else begin
                  r_tx_nbit <= r_tx_nbit + 4'd1;
                  r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
               end
            end else begin
               r_tx_cnt <= r_tx_cnt + 16'd1;
            end
         end
`ifdef RS232_ECHO_EN
         if (w_byte_valid && r_tx_busy && !r_tx_reply) begin
            r_echo_pend <= 1'b1;
            r_echo_byte <= r_rx_shift;
         end
`endif
      end
   end

   assign tx = r_tx_sh[0];

endmodule
`default_nettype wire

// File: tb/tb_rs232_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rs232_link                                              |
// | Desc    : directed self-checking bench for rs232_link (echo off).    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_rs232_link;
   // CLK_HZ scaled down so bit periods are 104/52/26 clocks
   localparam int CPB0  = 104;
   localparam int CPB1  = 52;
   localparam int CPB38 = 26;

   logic        clk;
   logic        rst;
   logic [13:0] r_LPF_threshold;
   logic [1:0]  buad_setting;
   logic        rx;
   logic        tx;
   logic [7:0]  data_debug;

   int checks = 0;
   int errors = 0;

   rs232_link #(
      .CLK_HZ          (1000000),
      .DEV_ADDR_HI     (8'h30),
      .DEV_ADDR_LO     (8'h32),
      .PKT_TIMEOUT_BITS(20)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .r_LPF_threshold(r_LPF_threshold),
      .buad_setting   (buad_setting),
      .rx             (rx),
      .tx             (tx),
      .data_debug     (data_debug)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int cpb);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         tick(cpb);
      end
   endtask

   task automatic send_packet(input logic [63:0] p, input int cpb);
      for (int i = 0; i < 8; i++) begin
         send_byte(p[63-8*i -: 8], cpb);
         tick(5);
      end
   endtask

   task automatic recv_byte(input int cpb, input int budget, output logic [7:0] b, output bit ok);
      int n;
      ok = 1'b0;
      b  = 8'h00;
      n  = 0;
      while (tx !== 1'b0 && n < budget) begin
         tick(1);
         n++;
      end
      if (tx !== 1'b0) return;
      tick(cpb / 2);
      if (tx !== 1'b0) return;
      for (int i = 0; i < 8; i++) begin
         tick(cpb);
         b[i] = tx;
      end
      tick(cpb);
      ok = (tx === 1'b1);
   endtask

   task automatic recv_reply(input logic [63:0] exp, input string name);
      logic [7:0] b;
      bit         ok;
      for (int i = 0; i < 8; i++) begin
         recv_byte(CPB38, (i == 0) ? 4000 : 3 * CPB38, b, ok);
         checks++;
         if (!ok || b !== exp[63-8*i -: 8]) begin
            errors++;
            $display("FAIL %s byte%0d got %h (frame ok=%0d) expected %h", name, i, b, ok, exp[63-8*i -: 8]);
         end
      end
   endtask

   task automatic do_read(input logic [15:0] exp_data, input string name);
      fork
         send_packet(64'h02_30_32_00_00_00_64_03, CPB38);
         recv_reply({8'h02, 8'h30, 8'h32, 16'h0000, exp_data, 8'h03}, name);
      join
      checks++;
      if (data_debug !== 8'h03) begin
         errors++;
         $display("FAIL %s_debug data_debug=%h expected 03", name, data_debug);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rx  = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(2);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx tx=%b expected 1", tx);
      end
      checks++;
      if (data_debug !== 8'h00) begin
         errors++;
         $display("FAIL reset_debug data_debug=%h expected 00", data_debug);
      end
      do_read(16'h0000, "reset_read");
   endtask

   task automatic test_write_read();
      send_packet(64'h02_30_32_30_33_01_C8_03, CPB38);
      checks++;
      if (data_debug !== 8'h03) begin
         errors++;
         $display("FAIL write_debug data_debug=%h expected 03", data_debug);
      end
      do_read(16'h01C8, "write_read");
   endtask

   task automatic test_addr_mismatch();
      send_packet(64'h02_30_33_30_33_AB_CD_03, CPB38);
      do_read(16'h01C8, "addr_mismatch");
   endtask

   task automatic test_timeout();
      send_byte(8'h02, CPB38); tick(5);
      send_byte(8'h30, CPB38); tick(5);
      send_byte(8'h32, CPB38); tick(5);
      send_byte(8'h30, CPB38);
      tick(22 * CPB38);
      send_byte(8'h33, CPB38); tick(5);
      send_byte(8'h55, CPB38); tick(5);
      send_byte(8'hAA, CPB38); tick(5);
      send_byte(8'h03, CPB38); tick(5);
      do_read(16'h01C8, "timeout");
   endtask

   task automatic test_glitch();
      buad_setting    = 2'd0;
      r_LPF_threshold = 14'd20;
      tick(5);
      rx = 1'b0; tick(15); rx = 1'b1;
      tick(300);
      checks++;
      if (data_debug !== 8'h03) begin
         errors++;
         $display("FAIL glitch_short data_debug=%h expected 03", data_debug);
      end
      repeat (50) begin
         rx = 1'b0; tick(15);
         rx = 1'b1; tick(2);
      end
      tick(1300);
      checks++;
      if (data_debug !== 8'h03) begin
         errors++;
         $display("FAIL glitch_train data_debug=%h expected 03", data_debug);
      end
      rx = 1'b0; tick(25); rx = 1'b1;
      tick(1300);
      checks++;
      if (data_debug !== 8'h03 || tx !== 1'b1) begin
         errors++;
         $display("FAIL false_start data_debug=%h tx=%b expected 03 and 1", data_debug, tx);
      end
      r_LPF_threshold = 14'd4;
   endtask

   task automatic test_baud();
      buad_setting = 2'd0;
      tick(5);
      send_byte(8'hA5, CPB0);
      tick(20);
      checks++;
      if (data_debug !== 8'hA5) begin
         errors++;
         $display("FAIL baud0_a5 data_debug=%h expected a5", data_debug);
      end
      send_byte(8'h00, CPB0);
      tick(20);
      checks++;
      if (data_debug !== 8'h00) begin
         errors++;
         $display("FAIL baud0_00 data_debug=%h expected 00", data_debug);
      end
      send_byte(8'hA5, CPB1);
      tick(1300);
      checks++;
      if (data_debug === 8'hA5) begin
         errors++;
         $display("FAIL baud_wrong_rate data_debug=%h expected anything but a5", data_debug);
      end
      buad_setting = 2'd1;
      tick(5);
      send_byte(8'h5A, CPB1);
      tick(20);
      checks++;
      if (data_debug !== 8'h5A) begin
         errors++;
         $display("FAIL baud1_5a data_debug=%h expected 5a", data_debug);
      end
      buad_setting = 2'd2;
      tick(5);
   endtask

   task automatic test_mid_reset();
      int low_seen;
      fork
         send_packet(64'h02_30_32_00_00_00_64_03, CPB38);
         begin
            tick(7 * (10 * CPB38 + 5) + 4 * CPB38);
            rst = 1'b0;
            tick(2);
            rst = 1'b1;
            tick(1);
            checks++;
            if (tx !== 1'b1 || data_debug !== 8'h00) begin
               errors++;
               $display("FAIL mid_reset_state tx=%b data_debug=%h expected 1 and 00", tx, data_debug);
            end
         end
      join
      low_seen = 0;
      repeat (3000) begin
         tick(1);
         if (tx !== 1'b1) low_seen++;
      end
      checks++;
      if (low_seen != 0) begin
         errors++;
         $display("FAIL mid_reset_no_reply tx low for %0d clocks expected 0", low_seen);
      end
      do_read(16'h0000, "mid_reset_read");
   endtask

   initial begin
      rst             = 1'b0;
      rx              = 1'b1;
      r_LPF_threshold = 14'd4;
      buad_setting    = 2'd2;
      test_reset();
      test_write_read();
      test_addr_mismatch();
      test_timeout();
      test_glitch();
      test_baud();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
